flex_stp_framed: RTL and testbench

Parametrised serial-to-parallel shift register with selectable shift direction and a built-in frame counter. It succeeds the fixed 4-bit STP block. It exposes the live shift contents, and also latches a completed word plus a one-cycle valid strobe every NUM_BITS enabled shifts. It sits behind serial receivers (e.g. UART/SPI RX datapaths) and feeds word-oriented consumers without an external bit counter.

---
 rtl/flex_stp_framed_if.sv | 25 ++
 rtl/flex_stp_framed.sv | 67 ++++++
 tb/tb_flex_stp_framed.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/flex_stp_framed_if.sv
// Serial-in / word-out bus for flex_stp_framed: serial controls in, live and framed words out.
// The receiver drives the master side; the shift register implements the slave side.
interface flex_stp_framed_if #(
    parameter int NUM_BITS = 8
);
    localparam int CW = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;

    logic                clear;
    logic                shift_enable;
    logic                serial_in;
    logic [NUM_BITS-1:0] parallel_out;
    logic [NUM_BITS-1:0] word_out;
    logic                word_valid;
    logic [CW-1:0]       bit_count;

    modport master (
        output clear, shift_enable, serial_in,
        input  parallel_out, word_out, word_valid, bit_count
    );

    modport slave (
        input  clear, shift_enable, serial_in,
        output parallel_out, word_out, word_valid, bit_count
    );
endinterface

// File: rtl/flex_stp_framed.sv
// Parametrised serial-to-parallel shift register with a frame counter that
// publishes a completed word and a one-cycle valid strobe every NUM_BITS shifts.
module flex_stp_framed #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b1,
    parameter bit RESET_BIT = 1'b1
) (
    input  logic              clk,
    input  logic              n_rst,
    flex_stp_framed_if.slave  bus
);
    localparam int            CW       = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);
    localparam logic [NUM_BITS-1:0] IDLE_WORD = {NUM_BITS{RESET_BIT}};

    logic [NUM_BITS-1:0] r_shift;
    logic [NUM_BITS-1:0] r_word;
    logic                r_valid;
    logic [CW-1:0]       r_count;

    logic [NUM_BITS-1:0] w_next_shift;
    logic                w_last_bit;

    generate
        if (SHIFT_MSB) begin : g_msb_first
            assign w_next_shift = {r_shift[NUM_BITS-2:0], bus.serial_in};
        end else begin : g_lsb_first
            assign w_next_shift = {bus.serial_in, r_shift[NUM_BITS-1:1]};
        end
    endgenerate

    // Compare against the last index so non-power-of-2 widths wrap correctly.
    assign w_last_bit = (r_count == LAST_BIT);

    // NOTE: every register here is sequential state, so all updates use <= to
    // avoid read-after-write ordering races between always_ff blocks.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_shift <= IDLE_WORD;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else if (bus.clear) begin
            // Frame abort keeps the last published word intact.
            r_shift <= IDLE_WORD;
            r_valid <= 1'b0;
            r_count <= '0;
        end else if (bus.shift_enable) begin
            r_shift <= w_next_shift;
            if (w_last_bit) begin
                r_count <= '0;
                r_word  <= w_next_shift;
                r_valid <= 1'b1;
            end else begin
                r_count <= r_count + CW'(1);
                r_valid <= 1'b0;
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign bus.parallel_out = r_shift;
    assign bus.word_out     = r_word;
    assign bus.word_valid   = r_valid;
    assign bus.bit_count    = r_count;
endmodule

// File: tb/tb_flex_stp_framed.sv
// Bench for flex_stp_framed: four configurations share one stimulus stream and are
// compared every cycle against a frame-level model, plus vector tables and corner sequences.
module tb_flex_stp_framed;
    logic clk;
    logic n_rst;
    logic clear;
    logic shift_enable;
    logic serial_in;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    flex_stp_framed_if #(.NUM_BITS(4)) if0 ();
    flex_stp_framed_if #(.NUM_BITS(4)) if1 ();
    flex_stp_framed_if #(.NUM_BITS(8)) if2 ();
    flex_stp_framed_if #(.NUM_BITS(5)) if3 ();

    assign if0.clear = clear; assign if0.shift_enable = shift_enable; assign if0.serial_in = serial_in;
    assign if1.clear = clear; assign if1.shift_enable = shift_enable; assign if1.serial_in = serial_in;
    assign if2.clear = clear; assign if2.shift_enable = shift_enable; assign if2.serial_in = serial_in;
    assign if3.clear = clear; assign if3.shift_enable = shift_enable; assign if3.serial_in = serial_in;

    flex_stp_framed #(.NUM_BITS(4), .SHIFT_MSB(1'b1), .RESET_BIT(1'b1)) u_d0 (.clk(clk), .n_rst(n_rst), .bus(if0));
    flex_stp_framed #(.NUM_BITS(4), .SHIFT_MSB(1'b0), .RESET_BIT(1'b1)) u_d1 (.clk(clk), .n_rst(n_rst), .bus(if1));
    flex_stp_framed #(.NUM_BITS(8), .SHIFT_MSB(1'b1), .RESET_BIT(1'b1)) u_d2 (.clk(clk), .n_rst(n_rst), .bus(if2));
    flex_stp_framed #(.NUM_BITS(5), .SHIFT_MSB(1'b1), .RESET_BIT(1'b0)) u_d3 (.clk(clk), .n_rst(n_rst), .bus(if3));

    logic [31:0] a_par[4];
    logic [31:0] a_word[4];
    logic [31:0] a_cnt[4];
    logic [31:0] a_valid[4];

    assign a_par[0] = 32'(if0.parallel_out); assign a_word[0] = 32'(if0.word_out);
    assign a_par[1] = 32'(if1.parallel_out); assign a_word[1] = 32'(if1.word_out);
    assign a_par[2] = 32'(if2.parallel_out); assign a_word[2] = 32'(if2.word_out);
    assign a_par[3] = 32'(if3.parallel_out); assign a_word[3] = 32'(if3.word_out);
    assign a_cnt[0] = 32'(if0.bit_count);    assign a_valid[0] = 32'(if0.word_valid);
    assign a_cnt[1] = 32'(if1.bit_count);    assign a_valid[1] = 32'(if1.word_valid);
    assign a_cnt[2] = 32'(if2.bit_count);    assign a_valid[2] = 32'(if2.word_valid);
    assign a_cnt[3] = 32'(if3.bit_count);    assign a_valid[3] = 32'(if3.word_valid);

    function automatic int cfg_bits(input int d);
        case (d)
            0: return 4;
            1: return 4;
            2: return 8;
            default: return 5;
        endcase
    endfunction

    function automatic bit cfg_msb(input int d);
        return (d != 1);
    endfunction

    function automatic bit cfg_rbit(input int d);
        return (d != 3);
    endfunction

    // Frame-level model: register value as an integer, bits captured so far in the frame.
    int unsigned m_par[4];
    int unsigned m_word[4];
    int unsigned m_cnt[4];
    int unsigned m_valid[4];

    task automatic model_update(input bit rst, input bit clr, input bit sh, input bit si);
        for (int d = 0; d < 4; d++) begin
            int unsigned n    = cfg_bits(d);
            int unsigned full = (32'd1 << n) - 1;
            int unsigned idle = cfg_rbit(d) ? full : 0;
            if (!rst) begin
                m_par[d] = idle; m_word[d] = 0; m_valid[d] = 0; m_cnt[d] = 0;
            end else if (clr) begin
                m_par[d] = idle; m_valid[d] = 0; m_cnt[d] = 0;
            end else if (sh) begin
                if (cfg_msb(d)) m_par[d] = ((m_par[d] * 2) + si) % (full + 1);
                else            m_par[d] = (m_par[d] / 2) + (int'(si) << (n - 1));
                m_cnt[d] = m_cnt[d] + 1;
                m_valid[d] = 0;
                if (m_cnt[d] == n) begin
                    m_cnt[d] = 0; m_word[d] = m_par[d]; m_valid[d] = 1;
                end
            end else begin
                m_valid[d] = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 4; d++) begin
            check($sformatf("d%0d_parallel_out", d), a_par[d],   m_par[d]);
            check($sformatf("d%0d_word_out", d),     a_word[d],  m_word[d]);
            check($sformatf("d%0d_word_valid", d),   a_valid[d], m_valid[d]);
            check($sformatf("d%0d_bit_count", d),    a_cnt[d],   m_cnt[d]);
        end
    endtask

    // Apply one edge's inputs, then sample outputs 1 time unit after the edge.
    task automatic step(input bit rst, input bit clr, input bit sh, input bit si);
        n_rst = rst; clear = clr; shift_enable = sh; serial_in = si;
        @(posedge clk);
        #1;
        model_update(rst, clr, sh, si);
        compare_all();
    endtask

    typedef struct {
        bit       rst;
        bit       clr;
        bit       sh;
        bit       si;
        logic [3:0] par;
        logic [3:0] word;
        bit       valid;
        logic [1:0] cnt;
    } vec_t;

    vec_t vq[$];

    initial begin
        logic [15:0] stream;
        n_rst = 1'b0; clear = 1'b0; shift_enable = 1'b0; serial_in = 1'b0;
        foreach (m_par[d]) begin
            m_par[d] = 0; m_word[d] = 0; m_cnt[d] = 0; m_valid[d] = 0;
        end

        // Hand-derived vectors for the N=4 MSB-first instance.
        vq.push_back('{0,0,0,0, 4'b1111, 4'b0000, 0, 2'd0});
        vq.push_back('{0,0,1,1, 4'b1111, 4'b0000, 0, 2'd0});
        vq.push_back('{1,0,1,1, 4'b1111, 4'b0000, 0, 2'd1});
        vq.push_back('{1,0,1,0, 4'b1110, 4'b0000, 0, 2'd2});
        vq.push_back('{1,0,1,1, 4'b1101, 4'b0000, 0, 2'd3});
        vq.push_back('{1,0,1,1, 4'b1011, 4'b1011, 1, 2'd0});
        vq.push_back('{1,0,0,0, 4'b1011, 4'b1011, 0, 2'd0});
        vq.push_back('{1,0,1,1, 4'b0111, 4'b1011, 0, 2'd1});
        vq.push_back('{1,0,1,1, 4'b1111, 4'b1011, 0, 2'd2});
        vq.push_back('{1,0,1,0, 4'b1110, 4'b1011, 0, 2'd3});
        vq.push_back('{1,0,0,1, 4'b1110, 4'b1011, 0, 2'd3});
        vq.push_back('{1,0,0,0, 4'b1110, 4'b1011, 0, 2'd3});
        vq.push_back('{1,0,0,1, 4'b1110, 4'b1011, 0, 2'd3});
        vq.push_back('{1,0,0,0, 4'b1110, 4'b1011, 0, 2'd3});
        vq.push_back('{1,0,0,1, 4'b1110, 4'b1011, 0, 2'd3});
        vq.push_back('{1,0,1,1, 4'b1101, 4'b1101, 1, 2'd0});
        vq.push_back('{1,0,1,0, 4'b1010, 4'b1101, 0, 2'd1});
        vq.push_back('{1,0,1,1, 4'b0101, 4'b1101, 0, 2'd2});
        vq.push_back('{1,0,1,1, 4'b1011, 4'b1101, 0, 2'd3});
        vq.push_back('{1,0,1,0, 4'b0110, 4'b0110, 1, 2'd0});
        vq.push_back('{1,0,1,1, 4'b1101, 4'b0110, 0, 2'd1});
        vq.push_back('{1,0,1,0, 4'b1010, 4'b0110, 0, 2'd2});
        vq.push_back('{1,1,1,1, 4'b1111, 4'b0110, 0, 2'd0});
        vq.push_back('{1,0,1,1, 4'b1111, 4'b0110, 0, 2'd1});
        vq.push_back('{1,0,1,0, 4'b1110, 4'b0110, 0, 2'd2});
        vq.push_back('{1,0,1,0, 4'b1100, 4'b0110, 0, 2'd3});
        vq.push_back('{1,0,1,1, 4'b1001, 4'b1001, 1, 2'd0});
        vq.push_back('{1,0,0,0, 4'b1001, 4'b1001, 0, 2'd0});
        vq.push_back('{1,0,1,1, 4'b0011, 4'b1001, 0, 2'd1});
        vq.push_back('{1,0,1,1, 4'b0111, 4'b1001, 0, 2'd2});
        vq.push_back('{1,0,1,1, 4'b1111, 4'b1001, 0, 2'd3});
        vq.push_back('{1,1,1,0, 4'b1111, 4'b1001, 0, 2'd0});
        vq.push_back('{1,0,0,0, 4'b1111, 4'b1001, 0, 2'd0});

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst, vq[i].clr, vq[i].sh, vq[i].si);
            check($sformatf("vec%0d_parallel_out", i), 32'(if0.parallel_out), 32'(vq[i].par));
            check($sformatf("vec%0d_word_out", i),     32'(if0.word_out),     32'(vq[i].word));
            check($sformatf("vec%0d_word_valid", i),   32'(if0.word_valid),   32'(vq[i].valid));
            check($sformatf("vec%0d_bit_count", i),    32'(if0.bit_count),    32'(vq[i].cnt));
            if (i == 5) begin
                check("lsb_first_word", 32'(if1.word_out), 32'h0000_000d);
                check("lsb_first_valid", 32'(if1.word_valid), 32'd1);
            end
        end

        // N=8 MSB-first: two back-to-back bytes, strobes only on the 8th and 16th shifts.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        stream = 16'hA53C;
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 1, stream[15-i]);
            check($sformatf("byte_valid_c%0d", i + 1), 32'(if2.word_valid),
                  ((i == 7) || (i == 15)) ? 32'd1 : 32'd0);
            if (i == 7)  check("byte_word_a5", 32'(if2.word_out), 32'h0000_00a5);
            if (i == 15) check("byte_word_3c", 32'(if2.word_out), 32'h0000_003c);
        end

        // N=5: count wraps by compare, then a mid-stream reset restores reset values.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, 1'($urandom_range(0, 1)));
            check($sformatf("n5_count_c%0d", i + 1), 32'(if3.bit_count), 32'((i + 1) % 5));
            check($sformatf("n5_valid_c%0d", i + 1), 32'(if3.word_valid),
                  ((i == 4) || (i == 9)) ? 32'd1 : 32'd0);
        end
        step(1, 0, 1, 1);
        step(0, 0, 1, 1);
        check("n5_rst_parallel_out", 32'(if3.parallel_out), 32'd0);
        check("n5_rst_word_out",     32'(if3.word_out),     32'd0);
        check("n5_rst_word_valid",   32'(if3.word_valid),   32'd0);
        check("n5_rst_bit_count",    32'(if3.bit_count),    32'd0);

        // Randomised traffic against the model for all four configurations.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
